// File: rtl/channel_pole_sequencer.sv
`default_nettype none
// ============================================================================
// channel_pole_sequencer : bank of complex one-pole sections sharing one MAC
// Rev 1.0
// ============================================================================
module channel_pole_sequencer #(
  parameter int NPOLE = 6,
  parameter int DW    = 16,
  parameter int CW    = 18,
  parameter int SW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [6:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  output logic          cfg_err,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_data,
  output logic          busy
);

  localparam int c_kw   = (NPOLE > 1) ? $clog2(NPOLE) : 1;
  localparam int c_pw   = CW + SW + 3;
  localparam int c_frac = 16;
  localparam logic [c_kw-1:0] c_klast = c_kw'(NPOLE - 1);
  localparam logic signed [c_pw-1:0] c_sat_max = {{(c_pw-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [c_pw-1:0] c_sat_min = {{(c_pw-SW+1){1'b1}}, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

  state_t               r_state;
  logic [c_kw-1:0]      r_k;
  logic signed [DW-1:0] r_x;
  logic signed [SW-1:0] r_acc;
  logic signed [SW-1:0] r_re     [NPOLE];
  logic signed [SW-1:0] r_im     [NPOLE];
  logic signed [CW-1:0] r_gain_r [NPOLE];
  logic signed [CW-1:0] r_gain_i [NPOLE];
  logic signed [CW-1:0] r_exp_r  [NPOLE];
  logic signed [CW-1:0] r_exp_i  [NPOLE];
  logic signed [CW-1:0] r_dc_gain;

  function automatic logic signed [SW-1:0] sat_sw(input logic signed [c_pw-1:0] v);
    if (v > c_sat_max)      return c_sat_max[SW-1:0];
    else if (v < c_sat_min) return c_sat_min[SW-1:0];
    else                    return v[SW-1:0];
  endfunction

  // Configuration decode
  logic [3:0] w_cfg_idx;
  logic [2:0] w_cfg_fld;
  logic       w_idx_ok;
  logic       w_cfg_ok;

  assign w_cfg_idx = cfg_addr[6:3];
  assign w_cfg_fld = cfg_addr[2:0];
  assign w_idx_ok  = (int'(w_cfg_idx) < NPOLE);
  assign w_cfg_ok  = (r_state == IDLE) &&
                     (((w_cfg_fld <= 3'd3) && w_idx_ok) || (w_cfg_fld == 3'd4));

  // Shared complex MAC, all operands widened so products keep full precision
  logic signed [c_pw-1:0] w_er, w_ei, w_gr, w_gi, w_re, w_im, w_x, w_dc, w_in;
  logic signed [c_pw-1:0] w_pre_re, w_pre_im;
  logic signed [SW-1:0]   w_new_re, w_new_im, w_acc_add, w_acc_dc;

  assign w_er = c_pw'(r_exp_r[r_k]);
  assign w_ei = c_pw'(r_exp_i[r_k]);
  assign w_gr = c_pw'(r_gain_r[r_k]);
  assign w_gi = c_pw'(r_gain_i[r_k]);
  assign w_re = c_pw'(r_re[r_k]);
  assign w_im = c_pw'(r_im[r_k]);
  assign w_x  = c_pw'(r_x);
  assign w_dc = c_pw'(r_dc_gain);
  assign w_in = c_pw'($signed(in_data));

  assign w_pre_re  = w_er * w_re - w_ei * w_im + w_gr * w_x;
  assign w_pre_im  = w_ei * w_re + w_er * w_im + w_gi * w_x;
  assign w_new_re  = sat_sw(w_pre_re >>> c_frac);
  assign w_new_im  = sat_sw(w_pre_im >>> c_frac);
  assign w_acc_add = sat_sw(c_pw'(r_acc) + w_re);
  assign w_acc_dc  = sat_sw((w_dc * w_in) >>> c_frac);

  assign in_ready = rst_n && (r_state == IDLE) && !cfg_we && !clr;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_dc_gain <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      for (int p = 0; p < NPOLE; p++) begin
        r_re[p]     <= '0;
        r_im[p]     <= '0;
        r_gain_r[p] <= '0;
        r_gain_i[p] <= '0;
        r_exp_r[p]  <= '0;
        r_exp_i[p]  <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !w_cfg_ok;
      if (cfg_we && w_cfg_ok) begin
        case (w_cfg_fld)
          3'd0:    r_gain_r[w_cfg_idx[c_kw-1:0]] <= $signed(cfg_wdata);
          3'd1:    r_gain_i[w_cfg_idx[c_kw-1:0]] <= $signed(cfg_wdata);
          3'd2:    r_exp_r[w_cfg_idx[c_kw-1:0]]  <= $signed(cfg_wdata);
          3'd3:    r_exp_i[w_cfg_idx[c_kw-1:0]]  <= $signed(cfg_wdata);
          default: r_dc_gain                     <= $signed(cfg_wdata);
        endcase
      end

      case (r_state)
        IDLE: begin
          if (clr) begin
            for (int p = 0; p < NPOLE; p++) begin
              r_re[p] <= '0;
              r_im[p] <= '0;
            end
          end
          if (in_valid && in_ready) begin
            r_x     <= $signed(in_data);
            r_acc   <= w_acc_dc;
            r_k     <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Accumulate the pre-update state, then advance the pole
          r_acc     <= w_acc_add;
          r_re[r_k] <= w_new_re;
          r_im[r_k] <= w_new_im;
          if (r_k == c_klast) begin
            out_data  <= w_acc_add;
            out_valid <= 1'b1;
            r_state   <= OUT;
          end else begin
            r_k <= r_k + c_kw'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
